// File: rtl/control32_pkg.sv
// Shared definitions for the multi-cycle Minisys controller: opcode/funct codes,
// FSM state encoding, the decoded control vector and the byte-enable helper.
package control32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_DECODE  = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_MDBUSY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;        // non-memory writeback; loads add theirs on completion
    logic       mem_read;
    logic       io_read;
    logic       io_write;
    logic       mem_or_io_to_reg;
    logic       branch;
    logic       nbranch;
    logic       jmp;
    logic       jal;
    logic       jr;
    logic       i_format;
    logic       sftmd;
    logic [1:0] alu_op;
    logic [3:0] mem_write;
    logic       do_byte;
    logic       do_half;
    logic       do_load;
    logic       do_signed;
    logic       is_load;
    logic       is_store;
    logic       is_md;
    logic       md_is_div;
    logic       hi_lo_write;
    logic [1:0] hi_lo_move;
    logic       misaligned;
  } ctrl_t;

  function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/control32_decode.sv
// Purely combinational opcode/funct decoder; tables match the single-cycle
// Minisys controller, extended with sub-word accesses and HI/LO operations.
module control32_decode
  import control32_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_io,
  input  logic [1:0] addr_lo,
  output ctrl_t      ctrl
);

  logic  r_type;
  logic  is_load;
  logic  is_store;
  logic  access;
  logic  is_mt;
  size_t size;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    r_type   = (opcode == OP_RTYPE);
    is_load  = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = opcode inside {OP_SB, OP_SH, OP_SW};
    access   = is_load | is_store;
    is_mt    = r_type && (funct[5:2] == 4'b0100) && funct[0];

    // The low two opcode bits encode the access size for every load/store.
    case (opcode[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase

    ctrl = '0;
    ctrl.is_load          = is_load;
    ctrl.is_store         = is_store;
    ctrl.i_format         = (opcode[5:3] == 3'b001);
    ctrl.reg_dst          = r_type;
    ctrl.jmp              = (opcode == OP_J);
    ctrl.jal              = (opcode == OP_JAL);
    ctrl.branch           = (opcode == OP_BEQ);
    ctrl.nbranch          = (opcode == OP_BNE);
    ctrl.jr               = r_type && (funct == FN_JR);
    ctrl.sftmd            = r_type && (funct[5:3] == 3'b000);
    ctrl.alu_src          = ctrl.i_format | access;
    ctrl.alu_op           = {r_type | ctrl.i_format, ctrl.branch | ctrl.nbranch};

    ctrl.is_md            = r_type && (funct[5:2] == 4'b0110);
    ctrl.md_is_div        = ctrl.is_md && funct[1];
    ctrl.hi_lo_write      = is_mt;
    ctrl.hi_lo_move       = {r_type && (funct == FN_MFHI), r_type && (funct == FN_MFLO)};

    ctrl.reg_write        = (r_type && !ctrl.jr && !ctrl.is_md && !is_mt)
                            | ctrl.i_format | ctrl.jal;

    ctrl.mem_read         = is_load && !is_io;
    ctrl.io_read          = is_load && is_io;
    ctrl.io_write         = is_store && is_io;
    ctrl.mem_or_io_to_reg = is_load;
    ctrl.mem_write        = (is_store && !is_io) ? byte_en(size, addr_lo) : 4'b0000;

    ctrl.do_byte          = access && (size == SZ_BYTE);
    ctrl.do_half          = access && (size == SZ_HALF);
    ctrl.do_load          = is_load;
    ctrl.do_signed        = is_load && !opcode[2];
    ctrl.misaligned       = access && (((size == SZ_HALF) && addr_lo[0]) ||
                                       ((size == SZ_WORD) && (addr_lo != 2'b00)));
  end

endmodule

// File: rtl/control32_mc.sv
// Multi-cycle Minisys controller: decodes each instruction and sequences
// memory/IO waits and mult/div occupancy, driving stall and commit to ifetch.
module control32_mc
  import control32_pkg::*;
#(
  parameter int unsigned                  ADDR_HIGH_W = 22,
  parameter logic [ADDR_HIGH_W-1:0]       IO_BASE     = {ADDR_HIGH_W{1'b1}},
  parameter int unsigned                  MULT_CYCLES = 4,
  parameter int unsigned                  DIV_CYCLES  = 32,
  parameter int unsigned                  WAIT_MAX    = 15
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Function_opcode,
  input  logic [ADDR_HIGH_W-1:0] ALUResultHigh,
  input  logic [1:0]             addr_lo,
  input  logic                   mem_ready,
  input  logic                   io_ready,
  output logic                   RegDST,
  output logic                   ALUSrc,
  output logic                   RegWrite,
  output logic                   MemRead,
  output logic                   IORead,
  output logic                   IOWrite,
  output logic                   MemOrIOtoReg,
  output logic                   Branch,
  output logic                   nBranch,
  output logic                   Jmp,
  output logic                   Jal,
  output logic                   Jr,
  output logic                   I_format,
  output logic                   Sftmd,
  output logic [1:0]             ALUOp,
  output logic [3:0]             MemWrite,
  output logic                   Do_Byte,
  output logic                   Do_Half,
  output logic                   Do_load,
  output logic                   Do_signed,
  output logic                   HI_LO_write,
  output logic [1:0]             HI_LO_move,
  output logic                   md_start,
  output logic                   md_is_div,
  output logic                   stall,
  output logic                   commit,
  output logic                   addr_err,
  output logic                   bus_err
);

  localparam int unsigned MD_MAX  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_MAX = (MD_MAX > WAIT_MAX) ? MD_MAX : WAIT_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [5:0]       lat_op, lat_fn;
  logic             lat_io;
  logic [1:0]       lat_lo;
  logic             capture;

  logic             in_decode;
  logic [5:0]       sel_op, sel_fn;
  logic             sel_io;
  logic [1:0]       sel_lo;
  logic             ready;
  logic             drive;
  logic [CNT_W-1:0] md_load;
  ctrl_t            ctrl;

  // While waiting, the decoder sees the captured instruction, not the live bus.
  assign in_decode = (state == ST_DECODE);
  assign sel_op    = in_decode ? Opcode          : lat_op;
  assign sel_fn    = in_decode ? Function_opcode : lat_fn;
  assign sel_io    = in_decode ? (ALUResultHigh == IO_BASE) : lat_io;
  assign sel_lo    = in_decode ? addr_lo         : lat_lo;
  assign ready     = sel_io ? io_ready : mem_ready;
  assign md_load   = ctrl.md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  control32_decode u_decode (
    .opcode  (sel_op),
    .funct   (sel_fn),
    .is_io   (sel_io),
    .addr_lo (sel_lo),
    .ctrl    (ctrl)
  );

  // NOTE: state and the captured instruction use non-blocking assignments so every
  // flop samples pre-edge values; the captured instruction is reset to keep it defined.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_DECODE;
      cnt    <= '0;
      lat_op <= '0;
      lat_fn <= '0;
      lat_io <= 1'b0;
      lat_lo <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        lat_op <= Opcode;
        lat_fn <= Function_opcode;
        lat_io <= (ALUResultHigh == IO_BASE);
        lat_lo <= addr_lo;
      end
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    capture      = 1'b0;
    RegDST       = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    IORead       = 1'b0;
    IOWrite      = 1'b0;
    MemOrIOtoReg = 1'b0;
    Branch       = 1'b0;
    nBranch      = 1'b0;
    Jmp          = 1'b0;
    Jal          = 1'b0;
    Jr           = 1'b0;
    I_format     = 1'b0;
    Sftmd        = 1'b0;
    ALUOp        = 2'b00;
    MemWrite     = 4'b0000;
    Do_Byte      = 1'b0;
    Do_Half      = 1'b0;
    Do_load      = 1'b0;
    Do_signed    = 1'b0;
    HI_LO_write  = 1'b0;
    HI_LO_move   = 2'b00;
    md_start     = 1'b0;
    md_is_div    = 1'b0;
    stall        = 1'b0;
    commit       = 1'b0;
    addr_err     = 1'b0;
    bus_err      = 1'b0;

    // Reset forces every output low even though DECODE may see a valid instruction.
    drive = rst_n && (!in_decode || instr_valid);

    if (drive) begin
      RegDST       = ctrl.reg_dst;
      ALUSrc       = ctrl.alu_src;
      RegWrite     = ctrl.reg_write;
      MemRead      = ctrl.mem_read;
      IORead       = ctrl.io_read;
      IOWrite      = ctrl.io_write;
      MemOrIOtoReg = ctrl.mem_or_io_to_reg;
      Branch       = ctrl.branch;
      nBranch      = ctrl.nbranch;
      Jmp          = ctrl.jmp;
      Jal          = ctrl.jal;
      Jr           = ctrl.jr;
      I_format     = ctrl.i_format;
      Sftmd        = ctrl.sftmd;
      ALUOp        = ctrl.alu_op;
      MemWrite     = ctrl.mem_write;
      Do_Byte      = ctrl.do_byte;
      Do_Half      = ctrl.do_half;
      Do_load      = ctrl.do_load;
      Do_signed    = ctrl.do_signed;
      HI_LO_write  = ctrl.hi_lo_write;
      HI_LO_move   = ctrl.hi_lo_move;

      case (state)
        ST_DECODE: begin
          if (ctrl.is_load || ctrl.is_store) begin
            if (ctrl.misaligned) begin
              addr_err = 1'b1;
              commit   = 1'b1;
              MemWrite = 4'b0000;
              MemRead  = 1'b0;
              IORead   = 1'b0;
              IOWrite  = 1'b0;
              RegWrite = 1'b0;
            end else if (ready) begin
              commit   = 1'b1;
              RegWrite = ctrl.is_load;
            end else begin
              stall   = 1'b1;
              capture = 1'b1;
              cnt_n   = '0;
              state_n = ST_MEMWAIT;
            end
          end else if (ctrl.is_md) begin
            md_start  = 1'b1;
            md_is_div = ctrl.md_is_div;
            if (md_load == '0) begin
              HI_LO_write = 1'b1;
              commit      = 1'b1;
            end else begin
              stall   = 1'b1;
              capture = 1'b1;
              cnt_n   = md_load;
              state_n = ST_MDBUSY;
            end
          end else begin
            commit = 1'b1;
          end
        end

        ST_MEMWAIT: begin
          if (ready) begin
            commit   = 1'b1;
            RegWrite = ctrl.is_load;
            state_n  = ST_DECODE;
          end else if (cnt == CNT_W'(WAIT_MAX)) begin
            bus_err  = 1'b1;
            commit   = 1'b1;
            RegWrite = 1'b0;
            state_n  = ST_DECODE;
          end else begin
            // Only incremented below WAIT_MAX, so the counter can never wrap.
            stall = 1'b1;
            cnt_n = cnt + CNT_W'(1);
          end
        end

        ST_MDBUSY: begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            HI_LO_write = 1'b1;
            commit      = 1'b1;
            state_n     = ST_DECODE;
          end else begin
            stall = 1'b1;
          end
        end

        default: state_n = ST_DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_control32_mc.sv
// Directed self-checking bench for control32_mc with hand-computed expectations.
module tb_control32_mc;

  logic        clock;
  logic        rst_n;
  logic        instr_valid;
  logic [5:0]  Opcode;
  logic [5:0]  Function_opcode;
  logic [21:0] ALUResultHigh;
  logic [1:0]  addr_lo;
  logic        mem_ready;
  logic        io_ready;
  logic        RegDST, ALUSrc, RegWrite, MemRead, IORead, IOWrite, MemOrIOtoReg;
  logic        Branch, nBranch, Jmp, Jal, Jr, I_format, Sftmd;
  logic [1:0]  ALUOp;
  logic [3:0]  MemWrite;
  logic        Do_Byte, Do_Half, Do_load, Do_signed;
  logic        HI_LO_write;
  logic [1:0]  HI_LO_move;
  logic        md_start, md_is_div, stall, commit, addr_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  control32_mc dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .Opcode          (Opcode),
    .Function_opcode (Function_opcode),
    .ALUResultHigh   (ALUResultHigh),
    .addr_lo         (addr_lo),
    .mem_ready       (mem_ready),
    .io_ready        (io_ready),
    .RegDST          (RegDST),
    .ALUSrc          (ALUSrc),
    .RegWrite        (RegWrite),
    .MemRead         (MemRead),
    .IORead          (IORead),
    .IOWrite         (IOWrite),
    .MemOrIOtoReg    (MemOrIOtoReg),
    .Branch          (Branch),
    .nBranch         (nBranch),
    .Jmp             (Jmp),
    .Jal             (Jal),
    .Jr              (Jr),
    .I_format        (I_format),
    .Sftmd           (Sftmd),
    .ALUOp           (ALUOp),
    .MemWrite        (MemWrite),
    .Do_Byte         (Do_Byte),
    .Do_Half         (Do_Half),
    .Do_load         (Do_load),
    .Do_signed       (Do_signed),
    .HI_LO_write     (HI_LO_write),
    .HI_LO_move      (HI_LO_move),
    .md_start        (md_start),
    .md_is_div       (md_is_div),
    .stall           (stall),
    .commit          (commit),
    .addr_err        (addr_err),
    .bus_err         (bus_err)
  );

  logic [32:0] all_out;
  assign all_out = {RegDST, ALUSrc, RegWrite, MemRead, IORead, IOWrite, MemOrIOtoReg,
                    Branch, nBranch, Jmp, Jal, Jr, I_format, Sftmd, ALUOp, MemWrite,
                    Do_Byte, Do_Half, Do_load, Do_signed, HI_LO_write, HI_LO_move,
                    md_start, md_is_div, stall, commit, addr_err, bus_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [21:0] hi, input logic [1:0] lo,
                       input logic mr, input logic ir);
    instr_valid     = v;
    Opcode          = op;
    Function_opcode = fn;
    ALUResultHigh   = hi;
    addr_lo         = lo;
    mem_ready       = mr;
    io_ready        = ir;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 6'b100011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    #3;
    check("reset_outs", all_out, '0);
    next_cycle();
    check("reset_hold", all_out, '0);
    rst_n = 1'b1;
    drive(1'b0, 6'b100011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("idle_zero", all_out, '0);
    next_cycle();

    // lw at 0x0000_1004, memory ready at once
    drive(1'b1, 6'b100011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("lw_fast", {MemRead, RegWrite, commit, stall, MemWrite, MemOrIOtoReg, IORead, ALUSrc},
          {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1});
    next_cycle();

    // sb at addr_lo=2, memory ready only in cycle 4; live bus scrambled while waiting
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) drive(1'b1, 6'b101000, 6'b0, 22'h0, 2'd2, 1'b0, 1'b0);
      else        drive(1'b0, 6'b000000, 6'b0, 22'h3FFFFF, 2'd0, 1'(c == 4), 1'b0);
      @(negedge clock);
      check($sformatf("sb_wait_c%0d", c), {IOWrite, MemWrite, stall, commit, bus_err, Do_Byte},
            {1'b0, 4'b0100, 1'(c < 4), 1'(c == 4), 1'b0, 1'b1});
      next_cycle();
    end

    // sw to IO space, io_ready stuck low, mem_ready high must be ignored
    for (int c = 1; c <= 17; c++) begin
      if (c == 1) drive(1'b1, 6'b101011, 6'b0, 22'h3FFFFF, 2'd0, 1'b1, 1'b0);
      else        drive(1'b0, 6'b000000, 6'b0, 22'h0, 2'd0, 1'b1, 1'b0);
      @(negedge clock);
      check($sformatf("sw_io_c%0d", c), {IOWrite, MemWrite, stall, commit, bus_err},
            {1'b1, 4'b0000, 1'(c < 17), 1'(c == 17), 1'(c == 17)});
      next_cycle();
    end
    drive(1'b0, 6'b0, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("after_bus_err_idle", all_out, '0);
    next_cycle();

    // div occupies 32 cycles in total
    for (int c = 1; c <= 32; c++) begin
      if (c == 1) drive(1'b1, 6'b000000, 6'b011010, 22'h0, 2'd0, 1'b0, 1'b0);
      else        drive(1'b0, 6'b000000, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
      @(negedge clock);
      check($sformatf("div_c%0d", c), {md_start, md_is_div, stall, HI_LO_write, commit, RegWrite},
            {1'(c == 1), 1'(c == 1), 1'(c < 32), 1'(c == 32), 1'(c == 32), 1'b0});
      next_cycle();
    end

    drive(1'b1, 6'b000000, 6'b010010, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("mflo", {HI_LO_move, RegWrite, commit, stall, HI_LO_write}, {2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
    next_cycle();

    // multu occupies 4 cycles in total
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) drive(1'b1, 6'b000000, 6'b011001, 22'h0, 2'd0, 1'b0, 1'b0);
      else        drive(1'b0, 6'b000000, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
      @(negedge clock);
      check($sformatf("multu_c%0d", c), {md_start, md_is_div, stall, HI_LO_write, commit},
            {1'(c == 1), 1'b0, 1'(c < 4), 1'(c == 4), 1'(c == 4)});
      next_cycle();
    end

    drive(1'b1, 6'b000000, 6'b010001, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("mthi", {HI_LO_write, RegWrite, commit, stall, HI_LO_move}, {1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
    next_cycle();

    drive(1'b1, 6'b000000, 6'b010000, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("mfhi", {HI_LO_move, RegWrite, commit}, {2'b10, 1'b1, 1'b1});
    next_cycle();

    // misaligned lh, then a normal lw
    drive(1'b1, 6'b100001, 6'b0, 22'h4, 2'd1, 1'b1, 1'b0);
    @(negedge clock);
    check("lh_misaligned", {addr_err, commit, MemRead, RegWrite, stall}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    next_cycle();
    drive(1'b1, 6'b100011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("lw_after_err", {addr_err, commit, MemRead, RegWrite, stall}, {1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    next_cycle();

    drive(1'b1, 6'b100011, 6'b0, 22'h4, 2'd2, 1'b1, 1'b0);
    @(negedge clock);
    check("lw_misaligned", {addr_err, commit, MemRead, RegWrite}, {1'b1, 1'b1, 1'b0, 1'b0});
    next_cycle();

    drive(1'b1, 6'b101001, 6'b0, 22'h4, 2'd3, 1'b1, 1'b0);
    @(negedge clock);
    check("sh_misaligned", {addr_err, commit, MemWrite}, {1'b1, 1'b1, 4'b0000});
    next_cycle();

    drive(1'b1, 6'b101001, 6'b0, 22'h4, 2'd2, 1'b1, 1'b0);
    @(negedge clock);
    check("sh_hi", {MemWrite, Do_Half, commit, RegWrite}, {4'b1100, 1'b1, 1'b1, 1'b0});
    next_cycle();

    drive(1'b1, 6'b101001, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("sh_lo", {MemWrite, Do_Half, commit}, {4'b0011, 1'b1, 1'b1});
    next_cycle();

    drive(1'b1, 6'b101011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("sw_mem", {MemWrite, IOWrite, commit, stall}, {4'b1111, 1'b0, 1'b1, 1'b0});
    next_cycle();

    drive(1'b1, 6'b100000, 6'b0, 22'h3FFFFF, 2'd3, 1'b0, 1'b1);
    @(negedge clock);
    check("lb_io", {IORead, MemRead, RegWrite, commit, Do_Byte, Do_signed, Do_load},
          {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    next_cycle();

    drive(1'b1, 6'b000000, 6'b100000, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("add", {RegDST, RegWrite, ALUOp, ALUSrc, commit, Sftmd}, {1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0});
    next_cycle();

    drive(1'b1, 6'b000100, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("beq", {Branch, nBranch, ALUOp, RegWrite, commit}, {1'b1, 1'b0, 2'b01, 1'b0, 1'b1});
    next_cycle();

    drive(1'b1, 6'b001000, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("addi", {I_format, ALUSrc, RegWrite, ALUOp, RegDST}, {1'b1, 1'b1, 1'b1, 2'b10, 1'b0});
    next_cycle();

    drive(1'b1, 6'b000000, 6'b001000, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("jr", {Jr, RegWrite, commit}, {1'b1, 1'b0, 1'b1});
    next_cycle();

    drive(1'b1, 6'b000011, 6'b0, 22'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("jal", {Jal, Jmp, RegWrite, commit}, {1'b1, 1'b0, 1'b1, 1'b1});
    next_cycle();

    // reset asserted during the second wait cycle of an sb
    drive(1'b1, 6'b101000, 6'b0, 22'h0, 2'd1, 1'b0, 1'b0);
    @(negedge clock);
    check("sb_rst_c1", {stall, MemWrite}, {1'b1, 4'b0010});
    next_cycle();
    drive(1'b1, 6'b101000, 6'b0, 22'h0, 2'd1, 1'b0, 1'b0);
    @(negedge clock);
    check("sb_rst_c2", {stall, MemWrite}, {1'b1, 4'b0010});
    next_cycle();
    drive(1'b1, 6'b101000, 6'b0, 22'h0, 2'd1, 1'b0, 1'b0);
    @(negedge clock);
    check("sb_rst_c3", {stall, commit}, {1'b1, 1'b0});
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("sb_rst_async", all_out, '0);
    next_cycle();
    check("sb_rst_no_commit", all_out, '0);
    rst_n = 1'b1;
    drive(1'b0, 6'b101000, 6'b0, 22'h0, 2'd1, 1'b1, 1'b0);
    @(negedge clock);
    check("post_rst_idle", all_out, '0);
    next_cycle();
    drive(1'b1, 6'b100011, 6'b0, 22'h4, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("post_rst_lw", {MemRead, RegWrite, commit, stall}, {1'b1, 1'b1, 1'b1, 1'b0});
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control32_mc.md
Name: control32_mc

Overview:
- Multi-cycle successor to the Minisys single-cycle decoder: decodes Opcode/Function_opcode into datapath controls and sequences instructions that need more than one cycle.
- Multi-cycle instructions are loads/stores waiting on memory or IO acknowledge, and mult/div occupying HI/LO for a fixed number of cycles.
- Sits between ifetch and the decoder/executs/memorio units. Drives `stall` back to ifetch and `commit` to retire each instruction.

Parameters:
- ADDR_HIGH_W, 22, width of the ALUResultHigh compare field.
- IO_BASE, {ADDR_HIGH_W{1'b1}}, ALUResultHigh value selecting the IO space.
- MULT_CYCLES, 4, total cycles for mult/multu (≥1).
- DIV_CYCLES, 32, total cycles for div/divu (≥1).
- WAIT_MAX, 15, maximum extra wait cycles on mem/io before bus error (≥1).

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  Opcode/Function_opcode valid this cycle (DECODE only)
- Opcode  in  6  instr[31:26]
- Function_opcode  in  6  instr[5:0]
- ALUResultHigh  in  ADDR_HIGH_W  effective address upper bits
- addr_lo  in  2  effective address [1:0]
- mem_ready  in  1  data memory acknowledge
- io_ready  in  1  IO acknowledge
- RegDST, ALUSrc, RegWrite, MemRead, IORead, IOWrite, MemOrIOtoReg, Branch, nBranch, Jmp, Jal, Jr, I_format, Sftmd  out  1 each  same meaning as the single-cycle controller
- ALUOp  out  2  {R_type|I_format, Branch|nBranch}
- MemWrite  out  4  byte enables
- Do_Byte, Do_Half, Do_load, Do_signed  out  1 each  access size, load, and sign-extension controls
- HI_LO_write  out  1  HI/LO capture strobe
- HI_LO_move  out  2  10 = mfhi, 01 = mflo, 00 = none
- md_start  out  1  one-cycle pulse starting the mult/div unit
- md_is_div  out  1  valid with md_start
- stall  out  1  hold PC/IR
- commit  out  1  instruction retires this cycle
- addr_err  out  1  misaligned access pulse
- bus_err  out  1  acknowledge timeout pulse

Behaviour:
- Reset (rst_n=0, asynchronous): state=DECODE, counters=0, latched instruction=0, all outputs 0.
- All outputs are 0 in any cycle where DECODE has instr_valid=0.
- Decode tables are identical to the single-cycle controller.
  - IO select: ALUResultHigh==IO_BASE.
  - Loads: 100000/100001/100011/100100/100101. Stores: 101000/101001/101011.
- Byte enables:
  - sb: 4'b0001<<addr_lo.
  - sh: addr_lo[1] ? 1100 : 0011.
  - sw: 1111.
  - Applied only on the memory path; IO uses IOWrite.
- Misalignment: halfword with addr_lo[0]=1, or word with addr_lo≠0.
  - addr_err=1 and commit=1 in the DECODE cycle.
  - MemWrite=0, MemRead/IORead/IOWrite=0, RegWrite=0.
  - State stays DECODE.
- FSM states: DECODE, MEMWAIT, MDBUSY.
- DECODE, single-cycle instruction: controls combinational, commit=1, stall=0.
- DECODE, aligned load/store:
  - Access strobes asserted.
  - If the selected ready (mem_ready, or io_ready for IO) is 1 in the same cycle: complete. commit=1; RegWrite=1 for loads; stay DECODE.
  - Otherwise: latch Opcode and IO/mem select, addr_lo, and size; stall=1; go to MEMWAIT; wait counter=0.
- MEMWAIT:
  - Re-drive the latched controls every cycle; ignore instr_valid; stall=1.
  - Completes when the selected ready=1: commit=1, stall=0, RegWrite=1 for loads, return to DECODE.
  - If the counter reaches WAIT_MAX with ready still 0: bus_err=1, commit=1, RegWrite=0, return to DECODE.
  - The counter saturates and never wraps.
- DECODE, R-type funct 0110xx:
  - md_start=1; md_is_div=funct[1].
  - Load cycle counter with MULT_CYCLES−1 or DIV_CYCLES−1; stall=1.
  - Go to MDBUSY; if the load value is 0, complete immediately as below.
- MDBUSY:
  - Decrement the counter; stall=1.
  - When the counter==0: HI_LO_write=1, commit=1, stall=0, return to DECODE.
- mfhi/mflo decoded in DECODE:
  - HI_LO_move set, RegWrite=1, single cycle.
  - Never coincide with MDBUSY, because ifetch is stalled.
- mthi/mtlo (0100x1): HI_LO_write=1 in one cycle, RegWrite=0.
- Reset asserted in MEMWAIT or MDBUSY: abort immediately to reset values. There is no commit and no HI_LO_write.

Decomposition:
- Package control32_pkg: opcode and funct localparams, FSM state enum (2-bit), byte-enable function.
- Sub-module control32_decode: purely combinational opcode/funct → control vector.
  - Instantiated once, fed by a mux selecting live inputs (DECODE) or latched registers (MEMWAIT/MDBUSY).

Test Plan:
- lw at address 0x0000_1004 with mem_ready=1 → same cycle: MemRead=1, RegWrite=1, commit=1, stall=0, MemWrite=0000.
- sb with addr_lo=2, mem_ready low for 3 cycles then high → MemWrite=0100 held 4 cycles; stall=1 for 3 cycles; commit only in cycle 4.
- sw with ALUResultHigh=22'h3FFFFF and io_ready stuck 0 (WAIT_MAX=15) → IOWrite held; bus_err=1 and commit=1 after 16 wait cycles; MemWrite stays 0000.
- div (funct 011010) with DIV_CYCLES=32 → md_start and md_is_div pulse once; stall=1 for 31 cycles; HI_LO_write=1 and commit=1 on cycle 32. Then mflo → HI_LO_move=01, RegWrite=1.
- lh with addr_lo=1 → addr_err=1, commit=1, MemRead=0, RegWrite=0; next lw proceeds normally.
- rst_n low at wait cycle 2 of a sb → all outputs 0 asynchronously, no commit; after release, DECODE with instr_valid=0 yields all-zero controls.
